// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter in front of a synchronous FIFO.
// NUM_REQ valid/ready producers share one w_en/WR port; a granted producer
// keeps the port for up to BURST_MAX accepted beats, then the grant rotates.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2,
  parameter int DATA_WIDTH = 4,
  parameter int BURST_MAX  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           fifo_full,
  output logic                           fifo_w_en,
  output logic [DATA_WIDTH-1:0]          fifo_wr,
  output logic [ID_WIDTH-1:0]            grant_id,
  output logic                           busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic [3:0]          LAST_BEAT  = 4'(BURST_MAX - 1);
  // Reset value of last_owner makes requester 0 the first one scanned.
  localparam logic [ID_WIDTH-1:0] START_LAST = ID_WIDTH'(NUM_REQ - 1);

  logic [0:0]            state;
  logic [ID_WIDTH-1:0]   owner;
  logic [ID_WIDTH-1:0]   last_owner;
  logic [3:0]            beat_cnt;

  logic                  owner_valid;
  logic [DATA_WIDTH-1:0] owner_data;
  logic [ID_WIDTH-1:0]   cand;
  logic [ID_WIDTH-1:0]   pick;
  logic                  found;
  logic                  xfer;

  // Select the current owner's valid bit and data word.
  always_comb begin
    owner_valid = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == ID_WIDTH'(i)) begin
        owner_valid = req_valid[i];
        owner_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Rotating priority scan starting just after the previous owner.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_WIDTH'((int'(last_owner) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Reset gates every strobe so nothing is written or accepted while rst is low.
  assign busy      = (state == GRANT);
  assign grant_id  = owner;
  assign xfer      = rst & busy & owner_valid & ~fifo_full;
  assign fifo_w_en = xfer;
  assign fifo_wr   = busy ? owner_data : '0;

  // Only the owner sees ready, and only while the FIFO has room.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = rst & busy & (owner == ID_WIDTH'(i)) & ~fifo_full;
    end
  end

  // Grant FSM: IDLE arbitrates, GRANT counts beats until burst end or valid drop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= START_LAST;
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            owner    <= pick;
            beat_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (!owner_valid) begin
            last_owner <= owner;
            beat_cnt   <= '0;
            state      <= IDLE;
          end else if (xfer) begin
            if (beat_cnt == LAST_BEAT) begin
              last_owner <= owner;
              beat_cnt   <= '0;
              state      <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
